// File: rtl/clock_time_keeper.sv
// clock_time_keeper: 1 Hz prescaler, 24 h HH:MM:SS counter with button-driven
// time setting, blinking of the field being set, and registered digit vectors
// for the downstream 8-digit multiplexed display driver.
// Digit vector format: bit5 enable (active-high), bits 4:1 BCD, bit0 dp (active-low).
// Optional build macro H12_DISPLAY_EN: show hours in 12 h form with a PM dot on d1;
// the internal hour count and the setting behaviour stay 24 h.
// The FSM state is visible on the registered mode output (0 RUN, 1 SET_H, 2 SET_M).
module clock_time_keeper #(
   parameter int TICK_COUNT  = 100000000,
   parameter int BLINK_COUNT = 25000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [5:0] d8,
   output logic [5:0] d7,
   output logic [5:0] d6,
   output logic [5:0] d5,
   output logic [5:0] d4,
   output logic [5:0] d3,
   output logic [5:0] d2,
   output logic [5:0] d1,
   output logic [1:0] mode,
   output logic       tick_1hz
);

   localparam int PW = $clog2(TICK_COUNT + 1);
   localparam int BW = $clog2(BLINK_COUNT + 1);
   localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_COUNT - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_COUNT - 1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;
   logic          btn_mode_q;
   logic          btn_inc_q;
   logic          mode_edge;
   logic          inc_edge;
   logic          tick_now;
   logic [PW-1:0] presc;
   logic [BW-1:0] blink_cnt;
   logic          blink_hidden;
   logic [4:0]    hours;
   logic [5:0]    minutes;
   logic [5:0]    seconds;

   logic [4:0]    disp_h;
   logic          h_tens_en;
   logic          pm_dp;
   logic          hide_h;
   logic          hide_m;
   logic [3:0]    h_tens;
   logic [3:0]    h_units;
   logic [3:0]    m_tens;
   logic [3:0]    m_units;
   logic [3:0]    s_tens;
   logic [3:0]    s_units;

   // Rising-edge actions; a mode edge wins over a simultaneous inc edge.
   assign mode_edge = btn_mode & ~btn_mode_q;
   assign inc_edge  = btn_inc & ~btn_inc_q & ~mode_edge;
   assign tick_now  = (state == RUN) && (presc == TICK_LAST);

   // Previous button levels for edge detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         btn_mode_q <= 1'b0;
         btn_inc_q  <= 1'b0;
      end else begin
         btn_mode_q <= btn_mode;
         btn_inc_q  <= btn_inc;
      end
   end

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_next;
   end

   // FSM next state: each mode edge steps RUN -> SET_H -> SET_M -> RUN.
   always_comb begin
      state_next = state;
      if (mode_edge) begin
         case (state)
            RUN:     state_next = SET_H;
            SET_H:   state_next = SET_M;
            default: state_next = RUN;
         endcase
      end
   end

   // Prescaler runs only while staying in RUN, so re-entering RUN restarts a full second.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc    <= '0;
         tick_1hz <= 1'b0;
      end else begin
         tick_1hz <= tick_now;
         if (state != RUN || state_next != RUN) presc <= '0;
         else if (tick_now)                     presc <= '0;
         else                                   presc <= presc + PW'(1);
      end
   end

   // Time counters: ticks with carry in RUN, per-field increments in the set states.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hours   <= '0;
         minutes <= '0;
         seconds <= '0;
      end else begin
         if (state == SET_M && state_next == RUN) begin
            seconds <= '0;
         end else if (tick_now) begin
            if (seconds == 6'd59) begin
               seconds <= '0;
               if (minutes == 6'd59) begin
                  minutes <= '0;
                  hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
               end else begin
                  minutes <= minutes + 6'd1;
               end
            end else begin
               seconds <= seconds + 6'd1;
            end
         end
         if (state == SET_H && inc_edge) hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
         if (state == SET_M && inc_edge) minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
      end
   end

   // Blink phase: restarts visible on every state change, idle in RUN.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         blink_cnt    <= '0;
         blink_hidden <= 1'b0;
      end else if (state_next != state || state == RUN) begin
         blink_cnt    <= '0;
         blink_hidden <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt    <= '0;
         blink_hidden <= ~blink_hidden;
      end else begin
         blink_cnt    <= blink_cnt + BW'(1);
      end
   end

   // Digit values, hour display form and blank control for the output registers.
   always_comb begin
      disp_h    = hours;
      h_tens_en = 1'b1;
      pm_dp     = 1'b1;
`ifdef H12_DISPLAY_EN
      if (hours == 5'd0)       disp_h = 5'd12;
      else if (hours > 5'd12)  disp_h = hours - 5'd12;
      pm_dp     = (hours >= 5'd12) ? 1'b0 : 1'b1;
      h_tens_en = (disp_h >= 5'd10);
`endif
      hide_h  = blink_hidden && (state == SET_H);
      hide_m  = blink_hidden && (state == SET_M);
      h_tens  = 4'(disp_h / 5'd10);
      h_units = 4'(disp_h % 5'd10);
      m_tens  = 4'(minutes / 6'd10);
      m_units = 4'(minutes % 6'd10);
      s_tens  = 4'(seconds / 6'd10);
      s_units = 4'(seconds % 6'd10);
   end

   // Registered display vectors and mode; reset shows "00.00 00".
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         d8   <= 6'b100001;
         d7   <= 6'b100000;
         d6   <= 6'b000001;
         d5   <= 6'b100000;
         d4   <= 6'b100001;
         d3   <= 6'b000001;
         d2   <= 6'b100001;
         d1   <= 6'b100001;
         mode <= 2'd0;
      end else begin
         d8   <= {h_tens_en & ~hide_h, h_tens, 1'b1};
         d7   <= {~hide_h, h_units, 1'b0};
         d6   <= 6'b000001;
         d5   <= {~hide_m, m_tens, 1'b0};
         d4   <= {~hide_m, m_units, 1'b1};
         d3   <= 6'b000001;
         d2   <= {1'b1, s_tens, 1'b1};
         d1   <= {1'b1, s_units, pm_dp};
         mode <= state;
      end
   end

endmodule

// File: tb/tb_clock_time_keeper.sv
// Testbench for clock_time_keeper with TICK_COUNT=10 and BLINK_COUNT=4.
// A small time/mode/blink model produces expected display words that are
// queued when stimulus is applied and compared when the outputs are sampled.
module tb_clock_time_keeper;

   localparam int TICK  = 10;
   localparam int BLINK = 4;
   localparam logic [49:0] RST_PAT = {2'b00, 6'b100001, 6'b100000, 6'b000001, 6'b100000,
                                      6'b100001, 6'b000001, 6'b100001, 6'b100001};

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [5:0] d8, d7, d6, d5, d4, d3, d2, d1;
   logic [1:0] mode;
   logic       tick_1hz;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [49:0] exp_q[$];
   logic [49:0] got;
   logic [49:0] exp;

   // model state
   int m_h = 0, m_m = 0, m_s = 0, m_st = 0, m_entry = 0;

   clock_time_keeper #(.TICK_COUNT(TICK), .BLINK_COUNT(BLINK)) dut (
      .clock(clock), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .d8(d8), .d7(d7), .d6(d6), .d5(d5), .d4(d4), .d3(d3), .d2(d2), .d1(d1),
      .mode(mode), .tick_1hz(tick_1hz)
   );

   // clock and cycle counter
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   function automatic logic [49:0] snap();
      return {mode, d8, d7, d6, d5, d4, d3, d2, d1};
   endfunction

   function automatic logic [49:0] exp_disp(int h, int m, int s, int st, bit hid);
      int dh;
      bit d8en, d1dp, hide_h, hide_m;
      logic [5:0] e8, e7, e5, e4, e2, e1;
      dh = h; d8en = 1'b1; d1dp = 1'b1;
`ifdef H12_DISPLAY_EN
      dh = (h == 0) ? 12 : (h > 12) ? h - 12 : h;
      d8en = (dh / 10) != 0;
      d1dp = (h >= 12) ? 1'b0 : 1'b1;
`endif
      hide_h = hid && (st == 1);
      hide_m = hid && (st == 2);
      e8 = {d8en & ~hide_h, 4'(dh / 10), 1'b1};
      e7 = {~hide_h, 4'(dh % 10), 1'b0};
      e5 = {~hide_m, 4'(m / 10), 1'b0};
      e4 = {~hide_m, 4'(m % 10), 1'b1};
      e2 = {1'b1, 4'(s / 10), 1'b1};
      e1 = {1'b1, 4'(s % 10), d1dp};
      return {2'(st), e8, e7, 6'b000001, e5, e4, 6'b000001, e2, e1};
   endfunction

   // expected display word for the outputs visible at the current negedge
   function automatic logic [49:0] cur_exp();
      int k;
      bit hid;
      k = cyc - 1 - m_entry;
      hid = (m_st != 0) && (k >= 0) && (((k / BLINK) % 2) == 1);
      return exp_disp(m_h, m_m, m_s, m_st, hid);
   endfunction

   // driver: one-cycle button pulse from a negedge, model updated alongside
   task automatic press(input bit do_mode, input bit do_inc);
      btn_mode = do_mode;
      btn_inc  = do_inc;
      if (do_mode) begin
         m_entry = cyc + 1;
         if (m_st == 2) m_s = 0;
         m_st = (m_st == 0) ? 1 : (m_st == 1) ? 2 : 0;
      end else if (do_inc) begin
         if (m_st == 1)      m_h = (m_h + 1) % 24;
         else if (m_st == 2) m_m = (m_m + 1) % 60;
      end
      @(negedge clock);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      got = snap();
      checks++;
      if (got !== RST_PAT) begin errors++; $display("FAIL reset_pattern: got %h expected %h", got, RST_PAT); end
      checks++;
      if (tick_1hz !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick_1hz); end
   endtask

   task automatic test_count();
      int ntick, first, last;
      bit spacing_ok;
      ntick = 0; first = -1; last = -1; spacing_ok = 1'b1;
      reset = 1'b0;
      for (int i = 1; i <= 605; i++) begin
         @(negedge clock);
         if (tick_1hz === 1'b1) begin
            if (first < 0) first = i;
            else if (i - last != TICK) spacing_ok = 1'b0;
            last = i;
            ntick++;
         end
      end
      checks++;
      if (first != TICK) begin errors++; $display("FAIL first_tick: got cycle %0d expected %0d", first, TICK); end
      checks++;
      if (ntick != 60) begin errors++; $display("FAIL tick_count: got %0d expected 60", ntick); end
      checks++;
      if (!spacing_ok) begin errors++; $display("FAIL tick_spacing: got irregular expected every %0d", TICK); end
      m_h = 0; m_m = 1; m_s = 0;
      exp_q.push_back(cur_exp());
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL count_00_01_00: got %h expected %h", got, exp); end
   endtask

   task automatic test_set_hours();
      press(1'b1, 1'b0);
      repeat (3) press(1'b0, 1'b1);
      exp_q.push_back(cur_exp());
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL set_h_three_inc: got %h expected %h", got, exp); end
      // held button: exactly one increment
      btn_inc = 1'b1;
      m_h = (m_h + 1) % 24;
      repeat (50) @(negedge clock);
      btn_inc = 1'b0;
      @(negedge clock);
      exp_q.push_back(cur_exp());
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL set_h_hold_once: got %h expected %h", got, exp); end
      // blink of the hours field over several phases
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         exp_q.push_back(cur_exp());
         got = snap(); exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin errors++; $display("FAIL blink_set_h[%0d]: got %h expected %h", i, got, exp); end
         checks++;
         if (tick_1hz !== 1'b0) begin errors++; $display("FAIL set_no_tick[%0d]: got %b expected 0", i, tick_1hz); end
      end
   endtask

   task automatic test_set_minutes();
      bit tick_ok;
      press(1'b1, 1'b0);
      while (m_m != 59) press(1'b0, 1'b1);
      exp_q.push_back(cur_exp());
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL set_m_59: got %h expected %h", got, exp); end
      press(1'b0, 1'b1);
      exp_q.push_back(cur_exp());
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL set_m_wrap_no_carry: got %h expected %h", got, exp); end
      // back to RUN: seconds cleared, first tick a full second later
      press(1'b1, 1'b0);
      exp_q.push_back(cur_exp());
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL run_entry_sec_clear: got %h expected %h", got, exp); end
      tick_ok = 1'b1;
      for (int j = 1; j <= TICK; j++) begin
         if (j > 1) @(negedge clock);
         if (tick_1hz !== (j == TICK)) tick_ok = 1'b0;
      end
      checks++;
      if (!tick_ok) begin errors++; $display("FAIL run_entry_tick_latency: got wrong tick timing expected tick at cycle %0d", TICK); end
      @(negedge clock);
      m_s = 1;
      exp_q.push_back(cur_exp());
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL run_first_second: got %h expected %h", got, exp); end
   endtask

   task automatic test_rollover();
      press(1'b1, 1'b0);
      while (m_h != 23) press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      while (m_m != 59) press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      repeat (59 * TICK) @(negedge clock);
      m_s = 59;
      exp_q.push_back(cur_exp());
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL preload_23_59_59: got %h expected %h", got, exp); end
      repeat (TICK) @(negedge clock);
      m_h = 0; m_m = 0; m_s = 0;
      exp_q.push_back(cur_exp());
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rollover_00_00_00: got %h expected %h", got, exp); end
   endtask

   task automatic test_simultaneous();
      press(1'b1, 1'b1);
      exp_q.push_back(cur_exp());
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL simul_run_to_set_h: got %h expected %h", got, exp); end
      press(1'b1, 1'b1);
      exp_q.push_back(cur_exp());
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL simul_set_h_to_set_m: got %h expected %h", got, exp); end
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      exp_q.push_back(cur_exp());
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL run_inc_ignored: got %h expected %h", got, exp); end
   endtask

   task automatic test_hour_13_view();
      press(1'b1, 1'b0);
      while (m_h != 13) press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      exp_q.push_back(cur_exp());
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL hour_13_view: got %h expected %h", got, exp); end
   endtask

   task automatic test_reset_midset();
      repeat (3) @(negedge clock);
      reset = 1'b1;
      #1;
      got = snap();
      checks++;
      if (got !== RST_PAT) begin errors++; $display("FAIL reset_async_midset: got %h expected %h", got, RST_PAT); end
      @(negedge clock);
      got = snap();
      checks++;
      if (got !== RST_PAT) begin errors++; $display("FAIL reset_held: got %h expected %h", got, RST_PAT); end
      reset = 1'b0;
      m_h = 0; m_m = 0; m_s = 0; m_st = 0;
      @(negedge clock);
      exp_q.push_back(cur_exp());
      got = snap(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL after_reset_run: got %h expected %h", got, exp); end
      checks++;
      if (tick_1hz !== 1'b0) begin errors++; $display("FAIL after_reset_tick: got %b expected 0", tick_1hz); end
   endtask

   initial begin
      test_reset();
      test_count();
      test_set_hours();
      test_set_minutes();
      test_rollover();
      test_simultaneous();
      test_hour_13_view();
      test_reset_midset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
